// File: rtl/gcd_engine.sv
// Single-clock GCD unit: captures both operands on start, then reduces them by
// subtractive Euclid (MODE=0) or binary Stein (MODE=1) until a terminal case is reached.
module gcd_engine #(
    parameter int WIDTH = 8,
    parameter int MODE  = 0,
    parameter int CW    = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] gcd_out,
    output logic             zero_err,
    output logic [CW-1:0]    iter_count
);

    localparam int KW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] ra, rb, ra_next, rb_next, gcd_next;
    logic [KW-1:0]    k, k_next;
    logic             zero_next;
    logic [CW-1:0]    iter_next;

    always_comb begin
        state_next = state;
        ra_next    = ra;
        rb_next    = rb;
        k_next     = k;
        gcd_next   = gcd_out;
        zero_next  = zero_err;
        iter_next  = iter_count;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    ra_next    = a_in;
                    rb_next    = b_in;
                    k_next     = '0;
                    iter_next  = '0;
                    zero_next  = 1'b0;
                    state_next = CALC;
                end
            end
            CALC: begin
                if (ra == '0 && rb == '0) begin
                    gcd_next   = '0;
                    zero_next  = 1'b1;
                    state_next = DONE;
                end else if (ra == '0 || rb == '0) begin
                    gcd_next   = (ra | rb) << k;
                    state_next = DONE;
                end else if (ra == rb) begin
                    gcd_next   = ra << k;
                    state_next = DONE;
                end else begin
                    if (iter_count != '1)
                        iter_next = iter_count + CW'(1);
                    // Both algorithms always subtract smaller from larger, so no underflow.
                    if (MODE == 0) begin
                        if (ra < rb)
                            rb_next = rb - ra;
                        else
                            ra_next = ra - rb;
                    end else begin
                        if (!ra[0] && !rb[0]) begin
                            ra_next = ra >> 1;
                            rb_next = rb >> 1;
                            k_next  = k + KW'(1);
                        end else if (!ra[0]) begin
                            ra_next = ra >> 1;
                        end else if (!rb[0]) begin
                            rb_next = rb >> 1;
                        end else if (ra > rb) begin
                            ra_next = (ra - rb) >> 1;
                        end else begin
                            rb_next = (rb - ra) >> 1;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // busy/done are registered from the next state so they track state exactly.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= IDLE;
            ra         <= '0;
            rb         <= '0;
            k          <= '0;
            gcd_out    <= '0;
            zero_err   <= 1'b0;
            iter_count <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_next;
            ra         <= ra_next;
            rb         <= rb_next;
            k          <= k_next;
            gcd_out    <= gcd_next;
            zero_err   <= zero_next;
            iter_count <= iter_next;
            busy       <= (state_next == CALC);
            done       <= (state_next == DONE);
        end
    end

endmodule
